sync_rr_arbiter: RTL
====================

Name: sync_rr_arbiter

Overview:
- Clocked round-robin arbiter sharing one four-phase (return-to-zero) request/acknowledge output channel (r0/a0) among N four-phase requester channels (r[i]/a[i]).
- Clocked, arbitrated counterpart of the two-input merge element. Used where more than two producers drive one downstream handshake consumer and fair, mutually exclusive service is required.
- Request and acknowledge inputs are asynchronous to clk and are synchronized internally.

Parameters:
- N, 2, number of requester channels (2..8).
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (r[i], a0); minimum 2.
- TIMEOUT, 64, clk cycles allowed in REQ or REL before err is set; 0 disables the watchdog.

Ports:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous active-low reset; asserts asynchronously, deasserts synchronously to clk (external synchronizer).
- r  input  N  four-phase requests, one bit per requester, asynchronous.
- a  output  N  four-phase acknowledges to requesters, one-hot or zero.
- r0  output  1  merged request to the shared consumer.
- a0  input  1  acknowledge from the shared consumer, asynchronous.
- gnt_id  output  max(1,clog2(N))  index of the current/last granted requester.
- busy  output  1  high in any state other than IDLE.
- err  output  1  sticky watchdog flag; cleared only by reset.

Behaviour:
- Synchronizers:
  - r_s[i] and a0_s are the last-stage outputs of SYNC_STAGES-deep flop chains.
  - All FSM decisions use only r_s and a0_s.
- Reset values: a=0, r0=0, gnt_id=0, busy=0, err=0, state=IDLE, sync flops=0, watchdog=0, rr pointer = requester 0 highest priority.
- All outputs are registered.
- FSM states: IDLE, REQ, ACK, REL.
- IDLE:
  - If any r_s[i]=1, select the winner g: the first set bit scanning upward (with wrap) from the highest-priority index.
  - At the next edge: r0<=1, gnt_id<=g, busy<=1, go to REQ.
- REQ:
  - r0=1; wait for a0_s=1.
  - When seen: a[g]<=1, go to ACK.
- ACK:
  - Wait for r_s[g]=0.
  - When seen: r0<=0, go to REL.
- REL:
  - Wait for a0_s=0.
  - When seen: a[g]<=0, busy<=0, set highest priority to (g+1) mod N, go to IDLE.
- At most one a[i] is high at any time; a[i] never rises unless r0 and a0_s are both high.
- Latency: r[i] rising before a clk edge shows r_s[i]=1 after SYNC_STAGES edges; r0 rises one edge later. The same holds for a0 to a[g], r_s[g] to r0 fall, and a0 to a[g] fall.
- Minimum turnaround: one cycle in IDLE between grants.
- Requests arriving during a grant are held pending, not lost. They are arbitrated in IDLE with the updated pointer.
- A requester dropping r before it receives a (protocol violation) is not tracked. The arbiter still completes the handshake: r0 falls in ACK as soon as r_s[g]=0.
- Watchdog:
  - Counter clears on every state entry and increments each cycle in REQ or REL.
  - When it reaches TIMEOUT, err<=1 (sticky).
  - The FSM does not abort; it keeps waiting so four-phase integrity holds.
  - The watchdog is inactive in IDLE and ACK.
- Reset mid-operation: all outputs drop immediately (asynchronous), including a[g] and r0. Any in-flight transaction is discarded. The rr pointer returns to requester 0.
- The simultaneous-request tie is resolved solely by the rr pointer.

Test Plan:
- Bench: clk period 10; a0 is r0 delayed by 120 time units; N=2, SYNC_STAGES=2, TIMEOUT=64.
1. Single request: after reset, r[0]=1.
   - Required sequence: r0 rises 3 edges later, then a[0]=1, gnt_id=0, busy=1.
   - Drop r[0]: r0 falls, then a[0]=0, busy=0. a[1] stays 0 throughout; err=0.
2. Simultaneous requests: r=2'b11 on the same edge after reset.
   - Requester 0 is served fully first, then requester 1. Each requester drops r[i] when it sees a[i].
   - Repeat r=2'b11: order is 0 then 1 again, since the pointer is at 0 after serving 1.
3. Round-robin fairness: r[0] held re-requesting continuously while r[1] pulses.
   - Grants alternate 0,1,0,1; gnt_id matches each a[i]; a is never 2'b11.
4. Watchdog: a0 forced 0, r[1]=1.
   - err rises 64 cycles after REQ entry; r0 stays 1; a stays 0.
   - Release a0 to follow r0: handshake completes normally; err remains 1.
5. Reset mid-handshake: assert reset_n=0 while in ACK with a[0]=1.
   - Same time step: a=0, r0=0, busy=0, err=0.
   - After release with r=2'b10: requester 1 is granted. Then with r=2'b11: requester 0 is granted first.
6. Pending request: r[1] rises while requester 0 is in REQ.
   - a[1] does not rise until a[0] has fallen.
   - r0 re-rises exactly one IDLE cycle after the previous grant returns to IDLE.

Source files
------------

// File: rtl/sync_rr_arbiter.sv
// rtl/sync_rr_arbiter.sv - clocked round-robin arbiter merging N four-phase request channels onto one
module sync_rr_arbiter #(
    parameter int N           = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64,
    localparam int IW         = (N > 1) ? $clog2(N) : 1,
    localparam int CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  r,
    output logic [N-1:0]  a,
    output logic          r0,
    input  logic          a0,
    output logic [IW-1:0] gnt_id,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;

    logic [N-1:0]           r_req_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [N-1:0]           w_req_s;
    logic                   w_ack_s;

    state_t                 r_state, w_state_nxt;
    logic [N-1:0]           r_a, w_a_nxt;
    logic                   r_r0, w_r0_nxt;
    logic [IW-1:0]          r_gnt, w_gnt_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_err, w_err_nxt;
    logic [IW-1:0]          r_ptr, w_ptr_nxt;
    logic [CW-1:0]          r_wdog, w_wdog_nxt;
    logic                   w_any;
    logic [IW-1:0]          w_win;
    logic                   w_wd_active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_req_sync[i] <= '0;
            r_ack_sync <= '0;
        end else begin
            r_req_sync[0] <= r;
            for (int i = 1; i < SYNC_STAGES; i++) r_req_sync[i] <= r_req_sync[i-1];
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], a0};
        end
    end

    assign w_req_s = r_req_sync[SYNC_STAGES-1];
    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // First pending requester at or after the pointer, wrapping round.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_any && w_req_s[(int'(r_ptr) + k) % N]) begin
                w_any = 1'b1;
                w_win = IW'((int'(r_ptr) + k) % N);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_r0_nxt    = r_r0;
        w_gnt_nxt   = r_gnt;
        w_busy_nxt  = r_busy;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_r0_nxt    = 1'b1;
                    w_gnt_nxt   = w_win;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (w_ack_s) begin
                    w_a_nxt        = '0;
                    w_a_nxt[r_gnt] = 1'b1;
                    w_state_nxt    = ACK;
                end
            end
            ACK: begin
                if (!w_req_s[r_gnt]) begin
                    w_r0_nxt    = 1'b0;
                    w_state_nxt = REL;
                end
            end
            REL: begin
                if (!w_ack_s) begin
                    w_a_nxt     = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = (r_gnt == IW'(N - 1)) ? '0 : r_gnt + 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Watchdog only flags a stall; the handshake keeps waiting so the channel stays consistent.
    assign w_wd_active = (r_state == REQ) || (r_state == REL);

    always_comb begin
        w_wdog_nxt = r_wdog;
        w_err_nxt  = r_err;
        if (w_state_nxt != r_state) begin
            w_wdog_nxt = '0;
        end else if (TIMEOUT != 0 && w_wd_active && r_wdog != CW'(TIMEOUT)) begin
            w_wdog_nxt = r_wdog + 1'b1;
            if (r_wdog == CW'(TIMEOUT - 1)) w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_r0    <= 1'b0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_r0    <= w_r0_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
            r_ptr   <= w_ptr_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

    assign a      = r_a;
    assign r0     = r_r0;
    assign gnt_id = r_gnt;
    assign busy   = r_busy;
    assign err    = r_err;

endmodule
